// File: rtl/seqdet_run_ctrl.sv
// Run controller for the run-length sequence detector: loads a pattern and limit,
// clears the detector, shifts the pattern in LSB first and tallies rises of z.
module seqdet_run_ctrl #(
    parameter int PW    = 16,
    parameter int DRAIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PW-1:0]         pattern,
    input  logic [$clog2(PW):0]   len,
    input  logic [3:0]            limit_cfg,
    output logic                  det_w,
    output logic                  det_rst,
    output logic [3:0]            det_limit,
    input  logic                  det_z,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [$clog2(PW)+1:0] hit_count,
    output logic [$clog2(PW)-1:0] first_hit_idx,
    output logic                  hit_valid
);
    localparam int IW = $clog2(PW) + 1;
    localparam int CW = $clog2(PW) + 2;
    localparam int FW = $clog2(PW);
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [IW-1:0] PW_LEN     = IW'(PW);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN > 0) ? DRAIN - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [PW-1:0] pat_q;
    logic [IW-1:0] len_q;
    logic [3:0]    lim_q;
    logic [IW-1:0] idx;
    logic [DW-1:0] drain_cnt;
    logic          z_prev;
    logic [IW-1:0] last_idx;
    logic          cfg_bad;
    logic          accept;
    logic          sample_en;
    logic          z_rise;
    logic [FW-1:0] hit_idx;

    assign last_idx  = len_q - IW'(1);
    assign cfg_bad   = (limit_cfg < 4'd2) || (len > PW_LEN);
    // The detector was held in reset during CLEAR, so its z is only trusted
    // from the second SHIFT cycle onward.
    assign sample_en = ((state == S_SHIFT) && (idx != '0)) || (state == S_DRAIN);
    assign z_rise    = sample_en && det_z && !z_prev;
    // idx stays parked on the last bit through DRAIN, which gives the clamp for free.
    assign hit_idx   = (state == S_DRAIN) ? idx[FW-1:0] : FW'(idx - IW'(1));
    assign det_limit = lim_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        det_rst = 1'b1;
        det_w   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (cfg_bad || (len == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                busy    = 1'b1;
                det_w   = pat_q[0];
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy    = 1'b1;
                det_rst = 1'b0;
                det_w   = pat_q[idx[FW-1:0]];
                if (idx == last_idx) begin
                    state_d = (DRAIN > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                det_rst = 1'b0;
                det_w   = pat_q[idx[FW-1:0]];
                if (drain_cnt == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q         <= '0;
            len_q         <= '0;
            lim_q         <= '0;
            idx           <= '0;
            drain_cnt     <= '0;
            z_prev        <= 1'b0;
            err           <= 1'b0;
            hit_count     <= '0;
            first_hit_idx <= '0;
            hit_valid     <= 1'b0;
        end else begin
            if (accept) begin
                pat_q         <= pattern;
                len_q         <= len;
                lim_q         <= limit_cfg;
                err           <= cfg_bad;
                hit_count     <= '0;
                first_hit_idx <= '0;
                hit_valid     <= 1'b0;
            end
            case (state)
                S_CLEAR: begin
                    idx       <= '0;
                    drain_cnt <= '0;
                    z_prev    <= 1'b0;
                end
                S_SHIFT: begin
                    if (idx != last_idx) begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                end
                default: begin
                end
            endcase
            if (sample_en) begin
                z_prev <= det_z;
                if (z_rise) begin
                    if (hit_count != '1) begin
                        hit_count <= hit_count + CW'(1);
                    end
                    if (!hit_valid) begin
                        hit_valid     <= 1'b1;
                        first_hit_idx <= hit_idx;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seqdet_run_ctrl.sv
// Bench for seqdet_run_ctrl: a behavioural run-length detector closes the loop,
// and expected results come from an array walk over the shifted bit sequence.
module tb_seqdet_run_ctrl;
    localparam int PW    = 16;
    localparam int DRAIN = 2;
    localparam int IW    = $clog2(PW) + 1;
    localparam int CW    = $clog2(PW) + 2;
    localparam int FW    = $clog2(PW);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] pattern;
    logic [IW-1:0] len;
    logic [3:0]    limit_cfg;
    logic          det_w;
    logic          det_rst;
    logic [3:0]    det_limit;
    logic          det_z;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] hit_count;
    logic [FW-1:0] first_hit_idx;
    logic          hit_valid;

    int   total = 0;
    int   bad = 0;
    logic use_model;
    logic manual_z;
    int   mdl_cnt = 0;
    logic mdl_prev = 1'b0;
    logic model_z;

    always #5 clk = ~clk;

    seqdet_run_ctrl #(.PW(PW), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .limit_cfg(limit_cfg), .det_w(det_w), .det_rst(det_rst), .det_limit(det_limit),
        .det_z(det_z), .busy(busy), .done(done), .err(err), .hit_count(hit_count),
        .first_hit_idx(first_hit_idx), .hit_valid(hit_valid)
    );

    // Behavioural detector: z is high once w has held one value for limit samples.
    always @(posedge clk) begin
        if (det_rst === 1'b1) begin
            mdl_cnt <= 0;
        end else begin
            if (mdl_cnt != 0 && det_w === mdl_prev) mdl_cnt <= (mdl_cnt < 15) ? mdl_cnt + 1 : 15;
            else mdl_cnt <= 1;
            mdl_prev <= det_w;
        end
    end
    assign model_z = (mdl_cnt != 0) && (mdl_cnt >= int'(det_limit));
    assign det_z   = use_model ? model_z : manual_z;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the bit sequence seen on w (pattern, then the last bit held through
    // DRAIN), track run lengths and report the rises of z visible to the controller.
    function automatic void expect_run(input logic [PW-1:0] pat, input int n, input int lim,
                                       output int hits, output int fidx, output bit fvalid);
        bit z[$];
        bit w;
        bit wp;
        int run;
        int cycles;
        cycles = n + DRAIN;
        hits = 0; fidx = 0; fvalid = 0; run = 0; wp = 0;
        z.push_back(1'b0);
        for (int c = 0; c < cycles; c++) begin
            w = pat[(c < n) ? c : n - 1];
            run = (c > 0 && w == wp) ? run + 1 : 1;
            wp = w;
            z.push_back(run >= lim);
        end
        for (int c = 1; c < cycles; c++) begin
            if (z[c] && !z[c-1]) begin
                hits++;
                if (!fvalid) begin
                    fvalid = 1;
                    fidx = (c - 1 < n) ? c - 1 : n - 1;
                end
            end
        end
    endfunction

    function automatic logic [PW-1:0] runny_pattern();
        logic [PW-1:0] p;
        logic b;
        b = 1'($urandom_range(0, 1));
        for (int i = 0; i < PW; i++) begin
            if ($urandom_range(0, 3) == 0) b = ~b;
            p[i] = b;
        end
        return p;
    endfunction

    task automatic test_reset();
        logic [19:0] rst_exp;
        rst_exp = {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 6'd0, 4'd0, 1'b0};
        rst = 1; start = 0;
        tick(); tick();
        total++; if ({det_w, det_rst, det_limit, busy, done, err, hit_count, first_hit_idx, hit_valid} !== rst_exp) begin bad++; $display("[TB] FAIL reset_state: got %h want %h", {det_w, det_rst, det_limit, busy, done, err, hit_count, first_hit_idx, hit_valid}, rst_exp); end
        rst = 0;
        tick();
    endtask

    task automatic test_model_run();
        logic [PW-1:0] seen_w;
        int  done_k;
        bit  rst_low_ok;
        int  eh, ef;
        bit  ev;
        seen_w = '0; done_k = -1; rst_low_ok = 1;
        use_model = 1;
        pattern = 16'h00F0; len = IW'(16); limit_cfg = 4'd4; start = 1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            start = 0;
            if (k >= 2 && k <= 17) begin
                seen_w[k-2] = det_w;
                if (det_rst !== 1'b0) rst_low_ok = 0;
            end
            if (done === 1'b1) begin done_k = k; break; end
        end
        expect_run(16'h00F0, 16, 4, eh, ef, ev);
        total++; if (seen_w !== 16'h00F0) begin bad++; $display("[TB] FAIL model_w_seq: got %h want %h", seen_w, 16'h00F0); end
        total++; if (rst_low_ok !== 1'b1) begin bad++; $display("[TB] FAIL model_det_rst_low: got %b want 1", rst_low_ok); end
        total++; if (done_k != 2 + 16 + DRAIN) begin bad++; $display("[TB] FAIL model_done_cycle: got %0d want %0d", done_k, 2 + 16 + DRAIN); end
        total++; if (hit_count !== CW'(3)) begin bad++; $display("[TB] FAIL model_hit_count: got %0d want 3", hit_count); end
        total++; if (hit_valid !== 1'b1) begin bad++; $display("[TB] FAIL model_hit_valid: got %b want 1", hit_valid); end
        total++; if (first_hit_idx !== FW'(ef)) begin bad++; $display("[TB] FAIL model_first_idx: got %0d want %0d", first_hit_idx, ef); end
        tick();
        total++; if (done !== 1'b0 || hit_count !== CW'(3)) begin bad++; $display("[TB] FAIL model_hold: got done=%b hits=%0d want done=0 hits=3", done, hit_count); end
    endtask

    task automatic test_manual_z();
        int done_k;
        done_k = -1;
        use_model = 0;
        manual_z = 1;
        pattern = runny_pattern(); len = IW'(8); limit_cfg = 4'd3; start = 1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            start = 0;
            manual_z = (k == 1) || (k == 5) || (k == 9) || (k == 11);
            if (done === 1'b1) begin done_k = k; break; end
        end
        manual_z = 0;
        total++; if (done_k != 2 + 8 + DRAIN) begin bad++; $display("[TB] FAIL manual_done_cycle: got %0d want %0d", done_k, 2 + 8 + DRAIN); end
        total++; if (hit_count !== CW'(3)) begin bad++; $display("[TB] FAIL manual_hit_count: got %0d want 3", hit_count); end
        total++; if (first_hit_idx !== FW'(2)) begin bad++; $display("[TB] FAIL manual_first_idx: got %0d want 2", first_hit_idx); end
        total++; if (hit_valid !== 1'b1) begin bad++; $display("[TB] FAIL manual_hit_valid: got %b want 1", hit_valid); end
        tick();
        use_model = 1;
    endtask

    task automatic test_bad_config();
        int   done_k;
        bit   rst_hi;
        logic err_at_done;
        logic [CW-1:0] hits_at_done;
        done_k = -1; rst_hi = 1; err_at_done = 0; hits_at_done = '1;
        pattern = runny_pattern(); len = IW'(8); limit_cfg = 4'd1; start = 1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            start = 0;
            if (det_rst !== 1'b1) rst_hi = 0;
            if (done === 1'b1 && done_k < 0) begin done_k = k; err_at_done = err; hits_at_done = hit_count; end
        end
        total++; if (done_k != 1) begin bad++; $display("[TB] FAIL badlim_done_cycle: got %0d want 1", done_k); end
        total++; if (err_at_done !== 1'b1) begin bad++; $display("[TB] FAIL badlim_err: got %b want 1", err_at_done); end
        total++; if (hits_at_done !== '0) begin bad++; $display("[TB] FAIL badlim_hits: got %0d want 0", hits_at_done); end
        total++; if (rst_hi !== 1'b1) begin bad++; $display("[TB] FAIL badlim_det_rst: got %b want 1", rst_hi); end
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL badlim_err_sticky: got %b want 1", err); end
        done_k = -1;
        len = IW'(20); limit_cfg = 4'd6; start = 1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            start = 0;
            if (done === 1'b1 && done_k < 0) begin done_k = k; err_at_done = err; end
        end
        total++; if (done_k != 1 || err_at_done !== 1'b1) begin bad++; $display("[TB] FAIL badlen: got done_k=%0d err=%b want done_k=1 err=1", done_k, err_at_done); end
    endtask

    task automatic test_len_zero();
        int   done_k;
        bit   busy_seen;
        logic err_at_done;
        done_k = -1; busy_seen = 0; err_at_done = 1'bx;
        pattern = runny_pattern(); len = '0; limit_cfg = 4'd5; start = 1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            start = 0;
            if (busy !== 1'b0) busy_seen = 1;
            if (done === 1'b1 && done_k < 0) begin done_k = k; err_at_done = err; end
        end
        total++; if (done_k != 1) begin bad++; $display("[TB] FAIL len0_done_cycle: got %0d want 1", done_k); end
        total++; if (err_at_done !== 1'b0) begin bad++; $display("[TB] FAIL len0_err: got %b want 0", err_at_done); end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("[TB] FAIL len0_busy: got %b want 0", busy_seen); end
        total++; if (hit_count !== '0 || hit_valid !== 1'b0) begin bad++; $display("[TB] FAIL len0_hits: got %0d/%b want 0/0", hit_count, hit_valid); end
    endtask

    task automatic test_mid_reset();
        logic [19:0]   rst_exp;
        logic [PW-1:0] p2;
        bit            done_seen;
        int            done_k;
        int            eh, ef;
        bit            ev;
        rst_exp = {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 6'd0, 4'd0, 1'b0};
        done_seen = 0; done_k = -1;
        pattern = runny_pattern(); len = IW'(16); limit_cfg = 4'd3; start = 1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            start = 0;
            if (done === 1'b1) done_seen = 1;
        end
        rst = 1;
        tick();
        rst = 0;
        total++; if ({det_w, det_rst, det_limit, busy, done, err, hit_count, first_hit_idx, hit_valid} !== rst_exp) begin bad++; $display("[TB] FAIL midrst_state: got %h want %h", {det_w, det_rst, det_limit, busy, done, err, hit_count, first_hit_idx, hit_valid}, rst_exp); end
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done === 1'b1) done_seen = 1;
        end
        total++; if (done_seen !== 1'b0) begin bad++; $display("[TB] FAIL midrst_no_done: got %b want 0", done_seen); end
        p2 = runny_pattern();
        pattern = p2; len = IW'(10); limit_cfg = 4'd3; start = 1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            start = 0;
            if (done === 1'b1) begin done_k = k; break; end
        end
        expect_run(p2, 10, 3, eh, ef, ev);
        total++; if (done_k != 2 + 10 + DRAIN) begin bad++; $display("[TB] FAIL midrst_rerun_done: got %0d want %0d", done_k, 2 + 10 + DRAIN); end
        total++; if (hit_count !== CW'(eh) || hit_valid !== ev || first_hit_idx !== FW'(ef)) begin bad++; $display("[TB] FAIL midrst_rerun_hits: got %0d/%b/%0d want %0d/%b/%0d", hit_count, hit_valid, first_hit_idx, eh, ev, ef); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] p1, p2, seen_w;
        logic [3:0]    l2;
        bit            lim_ok;
        int            done_k;
        int            eh, ef;
        bit            ev;
        p1 = runny_pattern(); p2 = runny_pattern(); l2 = 4'd3;
        seen_w = '0; lim_ok = 1; done_k = -1;
        pattern = p1; len = IW'(12); limit_cfg = 4'd5; start = 1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            pattern = PW'($urandom); limit_cfg = 4'($urandom_range(2, 15)); len = IW'($urandom_range(1, 16));
            if (det_limit !== 4'd5) lim_ok = 0;
            if (k >= 2 && k <= 13) seen_w[k-2] = det_w;
            if (done === 1'b1) begin done_k = k; break; end
        end
        expect_run(p1, 12, 5, eh, ef, ev);
        total++; if (done_k != 2 + 12 + DRAIN) begin bad++; $display("[TB] FAIL b2b_done_cycle: got %0d want %0d", done_k, 2 + 12 + DRAIN); end
        total++; if (lim_ok !== 1'b1) begin bad++; $display("[TB] FAIL b2b_limit_stable: got %b want 1", lim_ok); end
        total++; if (seen_w[11:0] !== p1[11:0]) begin bad++; $display("[TB] FAIL b2b_w_seq: got %h want %h", seen_w[11:0], p1[11:0]); end
        total++; if (hit_count !== CW'(eh) || hit_valid !== ev || first_hit_idx !== FW'(ef)) begin bad++; $display("[TB] FAIL b2b_hits: got %0d/%b/%0d want %0d/%b/%0d", hit_count, hit_valid, first_hit_idx, eh, ev, ef); end
        // start is still high: ignored in DONE, accepted in the IDLE cycle after it
        pattern = p2; len = IW'(9); limit_cfg = l2;
        tick();
        tick();
        start = 0;
        total++; if (busy !== 1'b1 || hit_count !== '0 || hit_valid !== 1'b0 || det_limit !== l2) begin bad++; $display("[TB] FAIL b2b_fresh_run: got busy=%b hits=%0d hv=%b lim=%0d want 1/0/0/%0d", busy, hit_count, hit_valid, det_limit, l2); end
        done_k = -1;
        for (int k = 2; k <= 60; k++) begin
            tick();
            if (done === 1'b1) begin done_k = k; break; end
        end
        expect_run(p2, 9, 3, eh, ef, ev);
        total++; if (done_k != 2 + 9 + DRAIN) begin bad++; $display("[TB] FAIL b2b_second_done: got %0d want %0d", done_k, 2 + 9 + DRAIN); end
        total++; if (hit_count !== CW'(eh) || hit_valid !== ev || first_hit_idx !== FW'(ef)) begin bad++; $display("[TB] FAIL b2b_second_hits: got %0d/%b/%0d want %0d/%b/%0d", hit_count, hit_valid, first_hit_idx, eh, ev, ef); end
        tick();
    endtask

    task automatic test_random();
        logic [PW-1:0] p;
        int n, lim, exp_k, eh, ef, done_k, busy_cnt;
        bit ev, exp_err;
        for (int it = 0; it < 40; it++) begin
            p = runny_pattern();
            n = $urandom_range(0, 20);
            lim = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 6);
            eh = 0; ef = 0; ev = 0;
            if (lim < 2 || n > PW) begin
                exp_err = 1; exp_k = 1;
            end else if (n == 0) begin
                exp_err = 0; exp_k = 1;
            end else begin
                exp_err = 0; exp_k = 2 + n + DRAIN;
                expect_run(p, n, lim, eh, ef, ev);
            end
            pattern = p; len = IW'(n); limit_cfg = 4'(lim); start = 1;
            done_k = -1; busy_cnt = 0;
            for (int k = 1; k <= 60; k++) begin
                tick();
                start = 0;
                pattern = PW'($urandom); limit_cfg = 4'($urandom);
                if (busy === 1'b1) busy_cnt++;
                if (done === 1'b1) begin done_k = k; break; end
            end
            total++; if (done_k != exp_k) begin bad++; $display("[TB] FAIL rnd%0d_done_cycle: got %0d want %0d (n=%0d lim=%0d)", it, done_k, exp_k, n, lim); end
            total++; if (err !== exp_err) begin bad++; $display("[TB] FAIL rnd%0d_err: got %b want %b", it, err, exp_err); end
            total++; if (busy_cnt != exp_k - 1) begin bad++; $display("[TB] FAIL rnd%0d_busy_cycles: got %0d want %0d", it, busy_cnt, exp_k - 1); end
            total++; if (hit_count !== CW'(eh) || hit_valid !== ev || first_hit_idx !== FW'(ef)) begin bad++; $display("[TB] FAIL rnd%0d_hits: got %0d/%b/%0d want %0d/%b/%0d (p=%h n=%0d lim=%0d)", it, hit_count, hit_valid, first_hit_idx, eh, ev, ef, p, n, lim); end
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    initial begin
        rst = 1; start = 0; pattern = '0; len = '0; limit_cfg = '0;
        use_model = 1; manual_z = 0;
        test_reset();
        test_model_run();
        test_manual_z();
        test_bad_config();
        test_len_zero();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seqdet_run_ctrl.md
Name: seqdet_run_ctrl

Overview:
- Sequencing controller for the run-length sequence detector, the FSM whose `z` asserts once `w` has held one value for `limit` consecutive cycles.
- Loads a test pattern word and a limit, then resets the detector.
- Shifts the pattern into the detector's `w` one bit per clock and watches `z`.
- Reports the hit count and the bit index of the first hit; sits between a host/test register block and one detector instance.

Parameters:
- PW, 16, pattern width in bits; `len` port is $clog2(PW)+1 bits wide.
- DRAIN, 2, cycles `z` is still monitored after the last bit is shifted out, covering detector latency.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle run request; sampled only in IDLE
- pattern  in  PW  bits to shift, LSB first; captured on accepted start
- len  in  $clog2(PW)+1  number of bits to shift (0..PW); captured on accepted start
- limit_cfg  in  4  run-length limit for the detector; captured on accepted start
- det_w  out  1  drives detector `w`
- det_rst  out  1  drives detector `rst`
- det_limit  out  4  drives detector `limit`; holds the captured limit
- det_z  in  1  detector `z`
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse on entry to DONE
- err  out  1  sticky until next accepted start; set when `limit_cfg` < 2 or `len` > PW
- hit_count  out  $clog2(PW)+2  rising edges of `det_z` seen this run; saturates at all-ones
- first_hit_idx  out  $clog2(PW)  index of the bit on `det_w` the cycle before the first `det_z` rise; 0 if none
- hit_valid  out  1  high once `first_hit_idx` is valid for the current run

Behaviour:
- Reset (rst=1 at posedge): state IDLE.
  - Outputs: det_w=0, det_rst=1, det_limit=0, busy=0, done=0, err=0, hit_count=0, first_hit_idx=0, hit_valid=0.
  - Internal: z_prev=0, bit index=0.
- Reset mid-run: aborts immediately, same values; no done pulse.
- States:
  - IDLE:
    - det_rst held 1.
    - start=1 captures pattern, len, limit_cfg; clears hit_count, hit_valid, first_hit_idx, err.
    - Invalid config (limit_cfg<2, or len>PW): err=1, go to DONE.
    - len=0: go to DONE with err=0 and hit_count=0.
    - Otherwise: go to CLEAR.
  - CLEAR: exactly 1 cycle.
    - det_rst=1, det_limit=captured limit, det_w=pattern[0].
    - Clear z_prev. Go to SHIFT.
  - SHIFT:
    - det_rst=0; det_w=pattern[idx], starting at idx=0 and incrementing each cycle.
    - After the cycle presenting idx=len-1, go to DRAIN.
  - DRAIN:
    - det_w holds the last bit; det_rst=0.
    - Exactly DRAIN cycles, then DONE.
  - DONE:
    - done=1 for this single cycle; det_rst returns to 1.
    - Next cycle IDLE; results hold until the next accepted start.
- Hit detection runs in SHIFT and DRAIN only:
  - z_prev is a register of det_z; a rise is det_z=1 & z_prev=0.
  - Each rise increments hit_count (saturating).
  - On the first rise: first_hit_idx = index driven on det_w in the previous cycle (clamped to len-1 during DRAIN); hit_valid=1.
  - det_z is ignored in IDLE, CLEAR and DONE.
  - det_z already high on the first SHIFT cycle does not count: z_prev was cleared in CLEAR, but det_z is sampled only from the second SHIFT cycle onward.
- start while busy or in DONE: ignored, not queued.
- det_limit stays stable for the whole run; changes on the limit_cfg input during a run have no effect.
- Bit index is $clog2(PW)+1 bits wide, so idx=PW-1 never wraps.

Test Plan:
- Bench behavioural detector model, limit_cfg=4, pattern=16'h00F0, len=16, one start:
  - det_w sequence 0,0,0,0,1,1,1,1,0…0 over 16 SHIFT cycles.
  - done pulse exactly 1+16+DRAIN+1 cycles after start.
  - hit_count=3, hit_valid=1.
  - first_hit_idx matches the model (zero-run reaches limit).
- Bench-driven det_z with three 1-cycle pulses (at SHIFT cycles 3 and 7, and in DRAIN cycle 1), len=8:
  - hit_count=3, first_hit_idx=2.
  - det_z pulse in IDLE before start does not count.
- start with limit_cfg=1:
  - err=1, done pulse 1 cycle after start, hit_count=0, det_rst never deasserts.
- start with len=0:
  - err=0, done next cycle, busy never asserts.
- rst=1 asserted in SHIFT cycle 5 of a len=16 run:
  - Next cycle all outputs at reset values, det_rst=1, no done pulse.
  - A new start afterwards runs normally.
- start re-asserted every cycle during a run:
  - Only the first start is accepted.
  - det_limit and the pattern stay unchanged until DONE.
  - A start in IDLE after DONE launches a fresh run with cleared counters.
